dram_cmd_seq: RTL
=================

DRAM_CMD_SEQ -- requirements
Module: dram_cmd_seq

Interface
REQ-001 The block SHALL have parameter T_DELAY, default 5, giving the cycles from one DRAM command to the earliest next command (range 2..15).
REQ-002 The block SHALL have parameter IDLE_CLOSE, default 16, giving the idle cycles with an open row before an automatic precharge (0 = never).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have these ports:
  clk  in  1  clock
  rst  in  1  async active-low reset
  req_valid  in  1  request present
  req_ready  out  1  request accepted when high with req_valid
  req_we  in  1  1 = write, 0 = read
  req_addr  in  32  byte address; row = [22:12], col = [11:2]
  req_wdata  in  32  write data
  req_wstrb  in  4  byte enables, active-high
  rsp_valid  out  1  response present
  rsp_ready  in  1  response consumed when high with rsp_valid
  rsp_rdata  out  32  read data; 0 for writes
  DRAM_CSn  out  1  chip select, active-low
  DRAM_RASn  out  1  row strobe, active-low
  DRAM_CASn  out  1  column strobe, active-low
  DRAM_WEn  out  4  per-byte write enable, active-low
  DRAM_A  out  11  row, or zero-extended col
  DRAM_D  out  32  write data
  DRAM_valid  in  1  read data valid
  DRAM_Q  in  32  read data

Function
REQ-005 The FSM SHALL have states IDLE, PRE, ACT, RD, RD_WAIT, WR, RESP.
REQ-006 req_ready SHALL be high only in IDLE, and only when the command timer has expired; the accepted request SHALL be registered in full on the handshake cycle.
REQ-007 On accept with row open and row equal: RD or WR. Row open and row different: PRE. No row open: ACT.
REQ-008 Each command SHALL last exactly one cycle:
  ACT: RASn=0, CASn=1, WEn=4'hF, A=row.
  PRE: RASn=0, CASn=1, WEn=4'h0.
  RD: RASn=1, CASn=0, WEn=4'hF, A={1'b0,col}.
  WR: RASn=1, CASn=0, WEn=~wstrb, A={1'b0,col}, D=wdata.
REQ-009 A 4-bit timer SHALL load T_DELAY-1 on every command cycle and decrement to 0; the next command SHALL issue only at timer==0, so commands are spaced exactly T_DELAY cycles apart.
REQ-010 When no command is active: RASn=CASn=1, WEn=4'hF, A=0, D=0. DRAM_CSn SHALL be 0 in every state after reset.
REQ-011 Sequencing:
  PRE is followed by ACT.
  ACT is followed by RD or WR, according to the registered req_we.
  RD is followed by RD_WAIT.
  RD_WAIT captures DRAM_Q into rsp_rdata on the first cycle with DRAM_valid=1, then goes to RESP.
  WR is followed by RESP after its timer expires.
REQ-012 In RESP, rsp_valid SHALL be 1 and rsp_rdata SHALL stay stable until rsp_ready=1; the block then returns to IDLE.
REQ-013 An open-row flag and an 11-bit row register SHALL be set by ACT and cleared by PRE.
REQ-014 In IDLE, an idle counter SHALL count cycles with the row open and req_valid=0. When it reaches IDLE_CLOSE, the block SHALL issue PRE (req_ready=0 on that cycle) and return to IDLE with the row closed.
REQ-015 If req_valid rises on the same cycle the idle counter hits IDLE_CLOSE, the request SHALL take priority and the counter SHALL clear.
REQ-016 DRAM_valid outside RD_WAIT SHALL be ignored. rsp_valid SHALL never be asserted outside RESP.

Reset
REQ-017 While rst=0, all outputs SHALL be:
  state IDLE, row closed, timer 0, idle counter 0
  req_ready=0, rsp_valid=0, rsp_rdata=0
  DRAM_CSn=1, RASn=1, CASn=1, WEn=4'hF, A=0, D=0
REQ-018 Reset asserted mid-sequence SHALL abandon the transaction with no response; the first request after release SHALL start with ACT.

Verification
REQ-019 Read from closed row, addr 0x0000_3008, T_DELAY=5: ACT A=0x003; RD A=0x002 five cycles later; DRAM_valid with Q=0xDEADBEEF -> rsp_valid with rdata 0xDEADBEEF.
REQ-020 Write to the same row, addr 0x0000_300C, wstrb 4'b0101, wdata 0x11223344 -> no ACT; WR with WEn=4'b1010, A=0x003, D=0x11223344; rsp_valid with rdata 0.
REQ-021 Read row 0x005 while row 0x003 is open -> PRE, ACT A=0x005, then RD, each exactly 5 cycles apart.
REQ-022 Row open, no requests for 16 cycles -> single PRE cycle (RASn=0, WEn=4'h0); the next request issues ACT.
REQ-023 rsp_ready held low 10 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0 throughout.
REQ-024 rst pulsed low during RD_WAIT -> all outputs at REQ-017 values immediately; the next read issues ACT.

Source files
------------

// File: rtl/dram_cmd_seq.sv
// Single-bank DRAM command sequencer: turns one-at-a-time read/write requests into
// PRE/ACT/RD/WR commands spaced T_DELAY cycles apart, with idle auto-precharge.
module dram_cmd_seq #(
  parameter int unsigned T_DELAY    = 5,
  parameter int unsigned IDLE_CLOSE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        DRAM_CSn,
  output logic        DRAM_RASn,
  output logic        DRAM_CASn,
  output logic [3:0]  DRAM_WEn,
  output logic [10:0] DRAM_A,
  output logic [31:0] DRAM_D,
  input  logic        DRAM_valid,
  input  logic [31:0] DRAM_Q
);

  localparam int unsigned TW  = 4;
  localparam int unsigned CW  = $clog2(IDLE_CLOSE + 2);
  localparam int unsigned RW  = 11;
  localparam int unsigned CLW = 10;

  typedef enum logic [2:0] {
    IDLE, PRE, ACT, RD, RD_WAIT, WR, RESP
  } state_t;

  state_t         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [CW-1:0]  idle_cnt_q, idle_cnt_d, idle_inc;
  logic           row_open_q, row_open_d;
  logic [RW-1:0]  row_q, row_d;
  logic           pend_q, pend_d;
  logic           we_q;
  logic [31:0]    addr_q, wdata_q;
  logic [3:0]     wstrb_q;

  logic           accept, issue;
  logic [31:0]    cur_addr, cur_wdata;
  logic [3:0]     cur_wstrb;
  logic [RW-1:0]  cur_row;
  logic [CLW-1:0] cur_col;

  logic           req_ready_d, rsp_valid_d;
  logic [31:0]    rsp_rdata_d, d_d;
  logic           ras_n_d, cas_n_d;
  logic [3:0]     we_n_d;
  logic [10:0]    a_d;

  logic           unused_addr_bits;
  assign unused_addr_bits = ^{cur_addr[31:23], cur_addr[1:0]};

  // Next state, timer, row tracking and the registered-output next values.
  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = '0;
    pend_d      = pend_q;
    rsp_rdata_d = rsp_rdata;
    row_open_d  = row_open_q;
    row_d       = row_q;
    ras_n_d     = 1'b1;
    cas_n_d     = 1'b1;
    we_n_d      = 4'hF;
    a_d         = '0;
    d_d         = '0;

    accept    = (state_q == IDLE) && req_ready && req_valid;
    // Commands issued on the accept cycle take fields straight from the request port.
    cur_addr  = accept ? req_addr  : addr_q;
    cur_wdata = accept ? req_wdata : wdata_q;
    cur_wstrb = accept ? req_wstrb : wstrb_q;
    cur_row   = cur_addr[22:12];
    cur_col   = cur_addr[11:2];
    idle_inc  = (idle_cnt_q < CW'(IDLE_CLOSE)) ? idle_cnt_q + CW'(1) : idle_cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          pend_d      = 1'b1;
          rsp_rdata_d = '0;
          if (row_open_q && (row_q == cur_row)) state_d = req_we ? WR : RD;
          else if (row_open_q)                  state_d = PRE;
          else                                  state_d = ACT;
        end else if (row_open_q && !req_valid && (IDLE_CLOSE != 0)) begin
          if ((idle_inc == CW'(IDLE_CLOSE)) && (timer_q == '0)) state_d = PRE;
          else                                                  idle_cnt_d = idle_inc;
        end
      end
      PRE: begin
        if (!pend_q)              state_d = IDLE;
        else if (timer_q == '0)   state_d = ACT;
      end
      ACT: begin
        if (timer_q == '0) state_d = we_q ? WR : RD;
      end
      RD:      state_d = RD_WAIT;
      RD_WAIT: begin
        if (DRAM_valid) begin
          rsp_rdata_d = DRAM_Q;
          state_d     = RESP;
        end
      end
      WR: begin
        if (timer_q == '0) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          pend_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    issue = (state_d != state_q) &&
            ((state_d == PRE) || (state_d == ACT) || (state_d == RD) || (state_d == WR));

    if (issue) begin
      case (state_d)
        PRE: begin
          ras_n_d    = 1'b0;
          we_n_d     = 4'h0;
          row_open_d = 1'b0;
          row_d      = '0;
        end
        ACT: begin
          ras_n_d    = 1'b0;
          a_d        = cur_row;
          row_open_d = 1'b1;
          row_d      = cur_row;
        end
        RD: begin
          cas_n_d = 1'b0;
          a_d     = {1'b0, cur_col};
        end
        WR: begin
          cas_n_d = 1'b0;
          we_n_d  = ~cur_wstrb;
          a_d     = {1'b0, cur_col};
          d_d     = cur_wdata;
        end
        default: ;
      endcase
    end

    timer_d     = issue ? TW'(T_DELAY - 1) : ((timer_q != '0) ? timer_q - TW'(1) : '0);
    req_ready_d = (state_d == IDLE) && (timer_d == '0);
    rsp_valid_d = (state_d == RESP);
  end

  // State, request capture and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      idle_cnt_q <= '0;
      row_open_q <= 1'b0;
      row_q      <= '0;
      pend_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      DRAM_CSn   <= 1'b1;
      DRAM_RASn  <= 1'b1;
      DRAM_CASn  <= 1'b1;
      DRAM_WEn   <= 4'hF;
      DRAM_A     <= '0;
      DRAM_D     <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      idle_cnt_q <= idle_cnt_d;
      row_open_q <= row_open_d;
      row_q      <= row_d;
      pend_q     <= pend_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
      req_ready  <= req_ready_d;
      rsp_valid  <= rsp_valid_d;
      rsp_rdata  <= rsp_rdata_d;
      DRAM_CSn   <= 1'b0;
      DRAM_RASn  <= ras_n_d;
      DRAM_CASn  <= cas_n_d;
      DRAM_WEn   <= we_n_d;
      DRAM_A     <= a_d;
      DRAM_D     <= d_d;
    end
  end

endmodule
